vaga_sensor_scanner: RTL

Scans four parking-slot presence sensors that share one active-low return line, using active-low per-slot strobes of the same form the display-digit demux produces. It is the reading side of that strobe interface: it drives one strobe at a time, samples the shared line, debounces each slot and keeps a registered occupancy map. It sits between the slot sensor harness and the occupancy/free-count display logic.

---
 rtl/vaga_sensor_scanner_if.sv | 30 +++
 rtl/vaga_sensor_scanner.sv | 101 ++++++++++
 2 files changed

// File: rtl/vaga_sensor_scanner_if.sv
// rtl/vaga_sensor_scanner_if.sv - strobe/return and occupancy signals of the slot sensor scanner
interface vaga_sensor_scanner_if;
    logic       en;
    logic       sense_n;
    logic [3:0] sel_n;
    logic [3:0] occupied;
    logic [2:0] free_count;
    logic       full;
    logic       changed;

    modport master (
        output en,
        output sense_n,
        input  sel_n,
        input  occupied,
        input  free_count,
        input  full,
        input  changed
    );

    modport slave (
        input  en,
        input  sense_n,
        output sel_n,
        output occupied,
        output free_count,
        output full,
        output changed
    );
endinterface

// File: rtl/vaga_sensor_scanner.sv
// rtl/vaga_sensor_scanner.sv - scans four slot sensors on a shared active-low return line
// Define SENSOR_DEBOUNCE_EN to debounce each slot over DEB_COUNT scans; otherwise each tick updates directly.
module vaga_sensor_scanner #(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vaga_sensor_scanner_if.slave bus
);
    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [1:0]       r_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_sel;
    logic [3:0]       r_occupied;
    logic             r_changed;

    logic             w_tick;
    logic             w_sample;
    logic             w_cur;
    logic [2:0]       w_ones;

    assign w_tick   = bus.en && (r_div == DIV_LAST);
    assign w_sample = ~r_sync[1];
    assign w_cur    = r_occupied[r_sel];

    // Synchronizer idles high so a reset never looks like a vehicle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_div  <= '0;
            r_sel  <= 2'd0;
        end else begin
            r_sync <= {r_sync[0], bus.sense_n};
            if (bus.en) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_sel <= r_sel + 2'd1;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    localparam logic [3:0] DEB_LAST = 4'(DEB_COUNT - 1);

    logic [3:0] r_deb [4];

    // Only the strobed slot's counter moves; a matching sample restarts its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb      <= '{default: 4'd0};
            r_occupied <= 4'b0000;
            r_changed  <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_tick) begin
                if (w_sample == w_cur) begin
                    r_deb[r_sel] <= 4'd0;
                end else if (r_deb[r_sel] == DEB_LAST) begin
                    r_deb[r_sel]      <= 4'd0;
                    r_occupied[r_sel] <= w_sample;
                    r_changed         <= 1'b1;
                end else begin
                    r_deb[r_sel] <= r_deb[r_sel] + 4'd1;
                end
            end
        end
    end
`else
    logic [3:0] w_unused_deb_count;
    assign w_unused_deb_count = 4'(DEB_COUNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupied <= 4'b0000;
            r_changed  <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (w_tick && (w_sample != w_cur)) begin
                r_occupied[r_sel] <= w_sample;
                r_changed         <= 1'b1;
            end
        end
    end
`endif

    assign w_ones = {2'b00, r_occupied[0]} + {2'b00, r_occupied[1]}
                  + {2'b00, r_occupied[2]} + {2'b00, r_occupied[3]};

    assign bus.sel_n      = bus.en ? ~(4'b0001 << r_sel) : 4'b1111;
    assign bus.occupied   = r_occupied;
    assign bus.free_count = 3'd4 - w_ones;
    assign bus.full       = &r_occupied;
    // A pulse landing while paused is suppressed so the bus stays quiet with en low.
    assign bus.changed    = r_changed & bus.en;
endmodule
